// File: rtl/uart_prog_loader_pkg.sv
// Shared encodings for the UART program loader: FSM states, command bytes
// and the byte/word geometry of assembled instructions.
package uart_prog_loader_pkg;

    localparam int NB_DATA        = 8;
    localparam int NB_WORD        = 32;
    localparam int NB_STATE       = 3;
    localparam int BYTES_PER_WORD = NB_WORD / NB_DATA;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    localparam logic [NB_DATA-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_DATA-1:0] CMD_RUN  = 8'h52;
    localparam logic [NB_DATA-1:0] CMD_HALT = 8'h48;
    localparam logic [NB_DATA-1:0] CMD_STEP = 8'h53;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 3'b001,
        ST_COUNT = 3'b010,
        ST_DATA  = 3'b100
    } state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte stream in from the UART receiver, instruction-memory writes and core
// control out. The loader sits on the slave side.
interface uart_prog_loader_if
    import uart_prog_loader_pkg::*;
#(
    parameter int NB_ADDR = 8
) ();

    logic               rx_done_tick_i;
    logic [NB_DATA-1:0] rx_data_i;
    logic               imem_we_o;
    logic [NB_ADDR-1:0] imem_addr_o;
    logic [NB_WORD-1:0] imem_data_o;
    logic               loading_o;
    logic               load_done_o;
    logic               run_o;
    logic               step_o;
    logic               cmd_err_o;

    modport slave (
        input  rx_done_tick_i, rx_data_i,
        output imem_we_o, imem_addr_o, imem_data_o,
        output loading_o, load_done_o, run_o, step_o, cmd_err_o
    );

    modport master (
        output rx_done_tick_i, rx_data_i,
        input  imem_we_o, imem_addr_o, imem_data_o,
        input  loading_o, load_done_o, run_o, step_o, cmd_err_o
    );

endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// saturates, flagging expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module uart_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clock,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [NB_CNT-1:0] cnt_q, cnt_d;

    // Expired means the current cycle is the last allowed idle one; the caller
    // aborts only if no byte shows up in it.
    assign expired_o = (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Command decoder behind the UART receiver: LOAD assembles big-endian words
// into instruction memory from address 0; RUN/HALT/STEP drive the core.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int NB_ADDR        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               reset_i,
    uart_prog_loader_if.slave  bus
);

    state_t                 state_q, state_d;
    logic                   run_q, run_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   we_q, we_d;
    logic [NB_ADDR-1:0]     addr_q, addr_d;
    logic [NB_WORD-1:0]     data_q, data_d;
    logic [NB_ADDR-1:0]     widx_q, widx_d;
    logic [BYTE_CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [NB_WORD-1:0]     word_q, word_d;
    logic [NB_DATA-1:0]     nwords_q, nwords_d;

    logic                   rx_tick;
    logic [NB_DATA-1:0]     rx_byte;
    logic                   tmo_expired;
    logic                   timeout;
    logic                   last_word;
    logic [NB_WORD-1:0]     shifted;

    assign rx_tick = bus.rx_done_tick_i;
    assign rx_byte = bus.rx_data_i;

    uart_byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset_i   (reset_i),
        .clear_i   (rx_tick || (state_q == ST_IDLE)),
        .enable_i  (state_q != ST_IDLE),
        .expired_o (tmo_expired)
    );

    // A byte landing on the expiry cycle wins over the abort.
    assign timeout   = tmo_expired && (state_q != ST_IDLE) && !rx_tick;
    assign shifted   = {word_q[NB_WORD-NB_DATA-1:0], rx_byte};
    assign last_word = (widx_q == NB_ADDR'(nwords_q - NB_DATA'(1)));

    // NOTE: every _d gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        addr_d   = addr_q;
        data_d   = data_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        nwords_d = nwords_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b0;
        we_d     = 1'b0;

        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            word_d  = '0;
            bcnt_d  = '0;
        end else if (rx_tick) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_byte)
                        CMD_LOAD: begin
                            if (run_q) err_d = 1'b1;
                            else       state_d = ST_COUNT;
                        end
                        CMD_RUN:  run_d = 1'b1;
                        CMD_HALT: run_d = 1'b0;
                        CMD_STEP: begin
                            if (run_q) err_d  = 1'b1;
                            else       step_d = 1'b1;
                        end
                        default:  err_d = 1'b1;
                    endcase
                end

                ST_COUNT: begin
                    if (rx_byte == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        nwords_d = rx_byte;
                        widx_d   = '0;
                        bcnt_d   = '0;
                        word_d   = '0;
                        state_d  = ST_DATA;
                    end
                end

                ST_DATA: begin
                    word_d = shifted;
                    if (bcnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
                        we_d   = 1'b1;
                        addr_d = widx_q;
                        data_d = shifted;
                        widx_d = widx_q + NB_ADDR'(1);
                        bcnt_d = '0;
                        if (last_word) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BYTE_CNT_W'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            widx_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            nwords_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            step_q   <= step_d;
            err_q    <= err_d;
            done_q   <= done_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            nwords_q <= nwords_d;
        end
    end

    assign bus.imem_we_o   = we_q;
    assign bus.imem_addr_o = addr_q;
    assign bus.imem_data_o = data_q;
    assign bus.loading_o   = (state_q != ST_IDLE);
    assign bus.load_done_o = done_q;
    assign bus.run_o       = run_q;
    assign bus.step_o      = step_q;
    assign bus.cmd_err_o   = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed vector table, timeout and
// reset sequences, then random traffic against a transaction-level model.
module tb_uart_prog_loader;

    localparam int TO = 16;
    localparam logic [7:0] B_LOAD = 8'h4C;
    localparam logic [7:0] B_RUN  = 8'h52;
    localparam logic [7:0] B_HALT = 8'h48;
    localparam logic [7:0] B_STEP = 8'h53;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        loading;
        logic        done;
        logic        run;
        logic        step;
        logic        err;
    } out_t;

    typedef struct packed {
        logic       tick;
        logic [7:0] b;
        out_t       exp;
    } vec_t;

    logic clock;
    logic reset_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_prog_loader_if #(.NB_ADDR(8)) bus ();

    uart_prog_loader #(
        .NB_ADDR        (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock   (clock),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic out_t sample();
        out_t o;
        o.we      = bus.imem_we_o;
        o.addr    = bus.imem_addr_o;
        o.data    = bus.imem_data_o;
        o.loading = bus.loading_o;
        o.done    = bus.load_done_o;
        o.run     = bus.run_o;
        o.step    = bus.step_o;
        o.err     = bus.cmd_err_o;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t a;
        a = sample();
        n_checks++;
        if (a !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%b addr=%h data=%h load=%b done=%b run=%b step=%b err=%b expected we=%b addr=%h data=%h load=%b done=%b run=%b step=%b err=%b",
                     name, a.we, a.addr, a.data, a.loading, a.done, a.run, a.step, a.err,
                     exp.we, exp.addr, exp.data, exp.loading, exp.done, exp.run, exp.step, exp.err);
        end
    endtask

    // One clock: present a byte (or none) and return just after the edge.
    task automatic drive(input logic tick, input logic [7:0] b);
        bus.rx_done_tick_i = tick;
        bus.rx_data_i      = b;
        @(posedge clock);
        #1;
        bus.rx_done_tick_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset_i            = 1'b1;
        bus.rx_done_tick_i = 1'b0;
        bus.rx_data_i      = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_i = 1'b0;
    endtask

    function automatic vec_t v(input logic tick, input logic [7:0] b, input logic we,
                               input logic [7:0] a, input logic [31:0] d, input logic ld,
                               input logic dn, input logic rn, input logic st, input logic er);
        vec_t r;
        r.tick = tick; r.b = b;
        r.exp.we = we; r.exp.addr = a; r.exp.data = d; r.exp.loading = ld;
        r.exp.done = dn; r.exp.run = rn; r.exp.step = st; r.exp.err = er;
        return r;
    endfunction

    // Reference model: keeps the whole LOAD payload and forms each word from
    // its four bytes once the payload length reaches a multiple of four.
    bit         m_run;
    int         m_phase;      // 0 command, 1 awaiting count, 2 payload
    int         m_n;
    int         m_quiet;
    logic [7:0] m_payload[$];
    out_t       m_exp;

    function automatic void model_reset();
        m_run = 0; m_phase = 0; m_n = 0; m_quiet = 0;
        m_payload.delete();
        m_exp = '0;
    endfunction

    function automatic void model_step(input logic tick, input logic [7:0] b);
        int k;
        m_exp.we = 0; m_exp.done = 0; m_exp.step = 0; m_exp.err = 0;
        if (tick) begin
            m_quiet = 0;
            if (m_phase == 0) begin
                if (b == B_LOAD) begin
                    if (m_run) m_exp.err = 1;
                    else       m_phase = 1;
                end else if (b == B_RUN) m_run = 1;
                else if (b == B_HALT) m_run = 0;
                else if (b == B_STEP) begin
                    if (m_run) m_exp.err = 1;
                    else       m_exp.step = 1;
                end else m_exp.err = 1;
            end else if (m_phase == 1) begin
                if (b == 8'h00) begin
                    m_exp.done = 1;
                    m_phase = 0;
                end else begin
                    m_n = int'(b);
                    m_payload.delete();
                    m_phase = 2;
                end
            end else begin
                m_payload.push_back(b);
                if (m_payload.size() % 4 == 0) begin
                    k = m_payload.size() / 4 - 1;
                    m_exp.we   = 1;
                    m_exp.addr = 8'(k);
                    m_exp.data = {m_payload[4*k], m_payload[4*k+1], m_payload[4*k+2], m_payload[4*k+3]};
                    if (k + 1 == m_n) begin
                        m_exp.done = 1;
                        m_phase = 0;
                    end
                end
            end
        end else if (m_phase != 0) begin
            m_quiet++;
            if (m_quiet >= TO) begin
                m_exp.err = 1;
                m_phase = 0;
                m_quiet = 0;
            end
        end
        m_exp.run     = m_run;
        m_exp.loading = (m_phase != 0);
    endfunction

    vec_t tbl[$];

    initial begin
        out_t       zero;
        logic       tick;
        logic [7:0] b;
        int         gap_left;
        int         r;

        zero = '0;
        do_reset();
        check_out("reset_state", zero);

        // Plan 1: two-word LOAD, write on 4th byte, done with the last write.
        tbl.push_back(v(1, 8'h4C, 0, 8'h00, 32'h0,         1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h02, 0, 8'h00, 32'h0,         1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h12, 0, 8'h00, 32'h0,         1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h34, 0, 8'h00, 32'h0,         1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h56, 0, 8'h00, 32'h0,         1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h78, 1, 8'h00, 32'h12345678,  1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h9A, 0, 8'h00, 32'h12345678,  1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'hBC, 0, 8'h00, 32'h12345678,  1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'hDE, 0, 8'h00, 32'h12345678,  1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'hF0, 1, 8'h01, 32'h9ABCDEF0,  0, 1, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 0));
        // Plan 2: zero-length LOAD.
        tbl.push_back(v(1, 8'h4C, 0, 8'h01, 32'h9ABCDEF0,  1, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h00, 0, 8'h01, 32'h9ABCDEF0,  0, 1, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 0));
        // Plan 3: run/halt/step interplay.
        tbl.push_back(v(1, 8'h52, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h52, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h53, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 1, 0, 1));
        tbl.push_back(v(1, 8'h4C, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 1, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 1, 0, 0));
        tbl.push_back(v(1, 8'h48, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h48, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h53, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 0));
        // Plan 4: unknown command byte.
        tbl.push_back(v(1, 8'h7F, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'h01, 32'h9ABCDEF0,  0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].tick, tbl[i].b);
            check_out($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Plan 5: timeout, including a byte that lands exactly on the expiry cycle.
        send(8'h4C); send(8'h01); send(8'hAA);
        for (int i = 0; i < TO - 1; i++) begin
            idle();
            check($sformatf("tmo_wait_a%0d {err,loading}", i), {62'd0, bus.cmd_err_o, bus.loading_o}, 64'd1);
        end
        send(8'hBB);
        check("tmo_byte_wins {err,loading}", {62'd0, bus.cmd_err_o, bus.loading_o}, 64'd1);
        for (int i = 0; i < TO - 1; i++) begin
            idle();
            check($sformatf("tmo_wait_b%0d {err,loading}", i), {62'd0, bus.cmd_err_o, bus.loading_o}, 64'd1);
        end
        idle();
        check("tmo_expire {we,done,err,loading}",
              {60'd0, bus.imem_we_o, bus.load_done_o, bus.cmd_err_o, bus.loading_o}, 64'b0010);
        idle();
        check("tmo_after {err,loading}", {62'd0, bus.cmd_err_o, bus.loading_o}, 64'd0);
        send(8'h4C); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
        check("tmo_no_early_we", {63'd0, bus.imem_we_o}, 64'd0);
        send(8'h44);
        check("tmo_reload {we,addr,data,done}",
              {22'd0, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o, bus.load_done_o},
              {22'd0, 1'b1, 8'h00, 32'h11223344, 1'b1});

        // Plan 6: asynchronous reset in the middle of a word.
        send(8'h4C); send(8'h02); send(8'hCA); send(8'hFE);
        #2 reset_i = 1'b1;
        #1 check_out("async_reset_now", zero);
        idle();
        check_out("reset_held", zero);
        @(negedge clock);
        reset_i = 1'b0;
        check_out("reset_released", zero);
        send(8'h4C); send(8'h01); send(8'h01); send(8'h02); send(8'h03);
        check("post_reset_no_we", {63'd0, bus.imem_we_o}, 64'd0);
        send(8'h04);
        check("post_reset_load {we,addr,data,done}",
              {22'd0, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o, bus.load_done_o},
              {22'd0, 1'b1, 8'h00, 32'h01020304, 1'b1});

        // Random traffic against the model, starting from a fresh reset.
        do_reset();
        model_reset();
        check_out("rand_reset", m_exp);
        gap_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (gap_left > 0) begin
                tick = 1'b0;
                gap_left--;
            end else if ($urandom_range(0, 59) == 0) begin
                tick = 1'b0;
                gap_left = $urandom_range(10, 20);
            end else begin
                tick = ($urandom_range(0, 3) != 0);
            end
            if (m_phase == 1) begin
                b = 8'($urandom_range(0, 3));
            end else if (m_phase == 2) begin
                b = 8'($urandom);
            end else begin
                r = $urandom_range(0, 9);
                if (r <= 2)      b = B_LOAD;
                else if (r == 3) b = B_RUN;
                else if (r <= 5) b = B_HALT;
                else if (r <= 7) b = B_STEP;
                else             b = 8'($urandom);
            end
            model_step(tick, b);
            drive(tick, b);
            check_out($sformatf("rand_cyc%0d", cyc), m_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
